ctrl_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit CSE141L core: fetches a 9-bit instruction, decodes the 3-bit opcode, drives the ALU opcode and register/memory controls, consumes the ALU `zero` flag for `bneg`, and owns the program counter. It sits upstream of the ALU and is the opcode producer for the same 3-bit operation interface the ALU decodes.

---
 rtl/ctrl_sequencer_if.sv | 36 +++
 rtl/ctrl_sequencer.sv | 159 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sequencer_if
//  Description : Control/instruction/memory bundle between ctrl_sequencer
//                and the datapath/memory side of the CSE141L core.
//  Revision    : 1.0  initial release
// ============================================================================
interface ctrl_sequencer_if;
    logic        start;
    logic [8:0]  instr;
    logic        zero;
    logic        mem_ack;
    logic [7:0]  pc;
    logic [2:0]  alu_op;
    logic [2:0]  rd_addr;
    logic [2:0]  rs_addr;
    logic        reg_we;
    logic        mem_req;
    logic        mem_we;
    logic        done;
    logic [15:0] cycle_cnt;
    logic [15:0] instr_cnt;

    modport master (
        input  start, instr, zero, mem_ack,
        output pc, alu_op, rd_addr, rs_addr, reg_we, mem_req, mem_we, done,
               cycle_cnt, instr_cnt
    );

    modport slave (
        output start, instr, zero, mem_ack,
        input  pc, alu_op, rd_addr, rs_addr, reg_we, mem_req, mem_we, done,
               cycle_cnt, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sequencer
//  Description : Multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC.
//                Define CTRL_PERF_CNT_EN to build the cycle/instruction counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_sequencer #(
    parameter logic [7:0] START_PC = 8'h00
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    ctrl_sequencer_if.master  bus
);

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_FETCH  = 3'd1;
    localparam state_t c_ST_DECODE = 3'd2;
    localparam state_t c_ST_EXEC   = 3'd3;
    localparam state_t c_ST_MEM    = 3'd4;
    localparam state_t c_ST_WB     = 3'd5;
    localparam state_t c_ST_HALT   = 3'd6;

    localparam logic [2:0] c_OP_STP  = 3'b000;
    localparam logic [2:0] c_OP_BNEG = 3'b010;
    localparam logic [2:0] c_OP_ST   = 3'b110;
    localparam logic [2:0] c_OP_LD   = 3'b111;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic [8:0] r_ir;
    logic [8:0] w_ir_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic [2:0] w_op;
    logic [7:0] w_br_off;

    assign w_op     = r_ir[8:6];
    assign w_br_off = {{5{r_ir[2]}}, r_ir[2:0]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
            r_pc    <= START_PC;
            r_ir    <= 9'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_done_nxt  = r_done;
        case (r_state)
            c_ST_IDLE, c_ST_HALT: begin
                if (bus.start) begin
                    w_pc_nxt    = START_PC;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_ir_nxt    = bus.instr;
                w_state_nxt = c_ST_DECODE;
            end
            c_ST_DECODE: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC: begin
                case (w_op)
                    c_OP_STP: begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_ST_HALT;
                    end
                    // zero flags a negative operand, so it selects the taken branch
                    c_OP_BNEG: begin
                        w_pc_nxt    = bus.zero ? (r_pc + w_br_off) : (r_pc + 8'd1);
                        w_state_nxt = c_ST_FETCH;
                    end
                    c_OP_ST, c_OP_LD: begin
                        w_pc_nxt    = r_pc + 8'd1;
                        w_state_nxt = c_ST_MEM;
                    end
                    default: begin
                        w_pc_nxt    = r_pc + 8'd1;
                        w_state_nxt = c_ST_WB;
                    end
                endcase
            end
            c_ST_MEM: begin
                if (bus.mem_ack) begin
                    w_state_nxt = (w_op == c_OP_ST) ? c_ST_FETCH : c_ST_WB;
                end
            end
            c_ST_WB: w_state_nxt = c_ST_FETCH;
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // outputs depend only on state and IR, never on zero/instr/mem_ack
    assign bus.pc      = r_pc;
    assign bus.done    = r_done;
    assign bus.rd_addr = r_ir[5:3];
    assign bus.rs_addr = r_ir[2:0];
    assign bus.alu_op  = ((r_state == c_ST_DECODE) || (r_state == c_ST_EXEC) ||
                          (r_state == c_ST_MEM)    || (r_state == c_ST_WB)) ? w_op : 3'b000;
    assign bus.reg_we  = (r_state == c_ST_WB);
    assign bus.mem_req = (r_state == c_ST_MEM);
    assign bus.mem_we  = (r_state == c_ST_MEM) && (w_op == c_OP_ST);

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_instr_cnt;
    logic        w_start_run;
    logic        w_busy;
    logic        w_retire;

    assign w_start_run = ((r_state == c_ST_IDLE) || (r_state == c_ST_HALT)) && bus.start;
    assign w_busy      = (r_state == c_ST_FETCH) || (r_state == c_ST_DECODE) ||
                         (r_state == c_ST_EXEC)  || (r_state == c_ST_MEM)    ||
                         (r_state == c_ST_WB);
    assign w_retire    = ((r_state == c_ST_EXEC) && ((w_op == c_OP_STP) || (w_op == c_OP_BNEG))) ||
                         ((r_state == c_ST_MEM) && bus.mem_ack && (w_op == c_OP_ST)) ||
                         (r_state == c_ST_WB);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cycle_cnt <= 16'h0000;
            r_instr_cnt <= 16'h0000;
        end else if (w_start_run) begin
            r_cycle_cnt <= 16'h0000;
            r_instr_cnt <= 16'h0000;
        end else begin
            if (w_busy && (r_cycle_cnt != 16'hFFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
            if (w_retire && (r_instr_cnt != 16'hFFFF)) begin
                r_instr_cnt <= r_instr_cnt + 16'd1;
            end
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`else
    assign bus.cycle_cnt = 16'h0000;
    assign bus.instr_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_sequencer
//  Description : Directed table-driven bench for ctrl_sequencer (START_PC = 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_sequencer;

    typedef struct {
        logic [8:0] instr;
        logic       zero;
        int         ack_wait;
        logic       noise;
        int         cycles;
        logic [7:0] exp_pc;
        logic [2:0] exp_alu;
        int         exp_we;
        int         exp_req;
        int         exp_mwe;
        logic       exp_done;
    } vec_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[18];

    ctrl_sequencer_if u_if();

    ctrl_sequencer #(.START_PC(8'h00)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (u_if)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic restart();
        u_if.start = 1'b1;
        @(posedge Clk); #1;
        u_if.start = 1'b0;
        chk("restart_done", {31'd0, u_if.done}, 0);
        chk("restart_pc", {24'd0, u_if.pc}, 0);
    endtask

    task automatic run_vec(input int idx);
        vec_t       v;
        int         we, req, mwe, mc;
        logic [2:0] alu_d, rd_d, rs_d;
        v = vecs[idx];
        we = 0; req = 0; mwe = 0; mc = 0;
        alu_d = 3'd0; rd_d = 3'd0; rs_d = 3'd0;
        u_if.instr   = v.instr;
        u_if.zero    = v.zero;
        u_if.start   = v.noise;
        u_if.mem_ack = v.noise;
        for (int c = 0; c < v.cycles; c++) begin
            if (c == 0) chk($sformatf("v%0d alu_op_fetch", idx), {29'd0, u_if.alu_op}, 0);
            if (c == 1) begin
                alu_d = u_if.alu_op;
                rd_d  = u_if.rd_addr;
                rs_d  = u_if.rs_addr;
            end
            if (u_if.reg_we) we++;
            if (u_if.mem_req) begin
                req++;
                if (u_if.mem_we) mwe++;
                u_if.mem_ack = (mc == v.ack_wait);
                mc++;
            end else begin
                u_if.mem_ack = v.noise;
            end
            @(posedge Clk); #1;
        end
        u_if.start   = 1'b0;
        u_if.mem_ack = 1'b0;
        chk($sformatf("v%0d pc", idx), {24'd0, u_if.pc}, {24'd0, v.exp_pc});
        chk($sformatf("v%0d alu_op", idx), {29'd0, alu_d}, {29'd0, v.exp_alu});
        chk($sformatf("v%0d rd_addr", idx), {29'd0, rd_d}, {29'd0, v.instr[5:3]});
        chk($sformatf("v%0d rs_addr", idx), {29'd0, rs_d}, {29'd0, v.instr[2:0]});
        chk($sformatf("v%0d reg_we_cycles", idx), we, v.exp_we);
        chk($sformatf("v%0d mem_req_cycles", idx), req, v.exp_req);
        chk($sformatf("v%0d mem_we_cycles", idx), mwe, v.exp_mwe);
        chk($sformatf("v%0d done", idx), {31'd0, u_if.done}, {31'd0, v.exp_done});
    endtask

    task automatic run_prog(input int first, input int last);
        int sum_cyc, exp_c, exp_i;
        sum_cyc = 0;
        restart();
        for (int i = first; i <= last; i++) begin
            run_vec(i);
            sum_cyc += vecs[i].cycles;
        end
`ifdef CTRL_PERF_CNT_EN
        exp_c = sum_cyc;
        exp_i = last - first + 1;
`else
        exp_c = 0;
        exp_i = 0;
`endif
        chk($sformatf("prog%0d cycle_cnt", first), {16'd0, u_if.cycle_cnt}, exp_c);
        chk($sformatf("prog%0d instr_cnt", first), {16'd0, u_if.instr_cnt}, exp_i);
    endtask

    initial begin
        int k;
        //            instr          zero  wait noise cyc  pc     alu   we req mwe done
        vecs[0]  = '{9'b100_001_010, 1'b0, 0, 1'b1, 4, 8'h01, 3'd4, 1, 0, 0, 1'b0};
        vecs[1]  = '{9'b001_011_100, 1'b0, 0, 1'b0, 4, 8'h02, 3'd1, 1, 0, 0, 1'b0};
        vecs[2]  = '{9'b011_111_000, 1'b1, 0, 1'b0, 4, 8'h03, 3'd3, 1, 0, 0, 1'b0};
        vecs[3]  = '{9'b101_010_101, 1'b0, 0, 1'b1, 4, 8'h04, 3'd5, 1, 0, 0, 1'b0};
        vecs[4]  = '{9'b111_100_001, 1'b0, 3, 1'b0, 8, 8'h05, 3'd7, 1, 4, 0, 1'b0};
        vecs[5]  = '{9'b010_000_110, 1'b1, 0, 1'b0, 3, 8'h03, 3'd2, 0, 0, 0, 1'b0};
        vecs[6]  = '{9'b110_001_011, 1'b0, 0, 1'b0, 4, 8'h04, 3'd6, 0, 1, 1, 1'b0};
        vecs[7]  = '{9'b100_110_111, 1'b0, 0, 1'b0, 4, 8'h05, 3'd4, 1, 0, 0, 1'b0};
        vecs[8]  = '{9'b010_000_110, 1'b0, 0, 1'b0, 3, 8'h06, 3'd2, 0, 0, 0, 1'b0};
        vecs[9]  = '{9'b010_000_100, 1'b1, 0, 1'b0, 3, 8'h02, 3'd2, 0, 0, 0, 1'b0};
        vecs[10] = '{9'b000_000_000, 1'b0, 0, 1'b0, 3, 8'h02, 3'd0, 0, 0, 0, 1'b1};
        vecs[11] = '{9'b010_000_100, 1'b1, 0, 1'b0, 3, 8'hFC, 3'd2, 0, 0, 0, 1'b0};
        vecs[12] = '{9'b010_000_011, 1'b1, 0, 1'b0, 3, 8'hFF, 3'd2, 0, 0, 0, 1'b0};
        vecs[13] = '{9'b100_000_001, 1'b0, 0, 1'b1, 4, 8'h00, 3'd4, 1, 0, 0, 1'b0};
        vecs[14] = '{9'b000_101_101, 1'b0, 0, 1'b0, 3, 8'h00, 3'd0, 0, 0, 0, 1'b1};
        vecs[15] = '{9'b100_001_010, 1'b0, 0, 1'b0, 4, 8'h01, 3'd4, 1, 0, 0, 1'b0};
        vecs[16] = '{9'b010_000_110, 1'b0, 0, 1'b0, 3, 8'h02, 3'd2, 0, 0, 0, 1'b0};
        vecs[17] = '{9'b000_000_000, 1'b0, 0, 1'b0, 3, 8'h02, 3'd0, 0, 0, 0, 1'b1};

        u_if.start   = 1'b0;
        u_if.instr   = 9'd0;
        u_if.zero    = 1'b0;
        u_if.mem_ack = 1'b0;
        Reset        = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_pc", {24'd0, u_if.pc}, 0);
        chk("rst_alu_op", {29'd0, u_if.alu_op}, 0);
        chk("rst_rd_rs", {26'd0, u_if.rd_addr, u_if.rs_addr}, 0);
        chk("rst_strobes", {28'd0, u_if.reg_we, u_if.mem_req, u_if.mem_we, u_if.done}, 0);
        chk("rst_counters", {u_if.cycle_cnt, u_if.instr_cnt}, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("idle_hold_pc", {24'd0, u_if.pc}, 0);

        run_prog(0, 10);
        run_prog(11, 14);
        run_prog(15, 17);

        // asynchronous reset landing in the middle of a stalled load
        restart();
        u_if.instr = 9'b111_000_000;
        k = 0;
        while (!u_if.mem_req && k < 10) begin
            @(posedge Clk); #1;
            k++;
        end
        chk("mid_mem_req_seen", {31'd0, u_if.mem_req}, 1);
        chk("mid_mem_pc", {24'd0, u_if.pc}, 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_mem_req", {31'd0, u_if.mem_req}, 0);
        chk("async_rst_pc", {24'd0, u_if.pc}, 0);
        chk("async_rst_done", {31'd0, u_if.done}, 0);
        chk("async_rst_alu_op", {29'd0, u_if.alu_op}, 0);
        @(posedge Clk);
        #3 Reset = 1'b0;
        u_if.mem_ack = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("post_rst_mem_req", {31'd0, u_if.mem_req}, 0);
        chk("post_rst_reg_we", {31'd0, u_if.reg_we}, 0);
        chk("post_rst_pc", {24'd0, u_if.pc}, 0);
        u_if.mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
